// File: rtl/bsa_pkg.sv
// Shared types for the bit-serial add/subtract unit.
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bsa_state_t;

endpackage

// File: rtl/bsa_if.sv
// Operand and result handshakes of the bit-serial adder, bundled for port lists.
interface bsa_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/full_adder_cell.sv
// Single-bit three-input adder; the only arithmetic in the bit-serial datapath.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit add/subtract that pushes one bit per cycle, LSB first, through one
// full-adder cell, with valid/ready handshakes on both operand and result sides.
module bit_serial_adder
  import bsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  bsa_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MSB_M1   = CNT_W'(WIDTH - 2);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("bit_serial_adder: WIDTH must be >= 2");
    end
  endgenerate

  bsa_state_t       r_state;
  bsa_state_t       w_next_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_c_msb_in;
  logic             r_cout;
  logic             r_ovf;

  logic w_s;
  logic w_co;
  logic w_in_ready;
  logic w_out_valid;
  logic w_last;

  full_adder_cell u_fa (
    .i_a    (r_opa[0]),
    .i_b    (r_opb[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_co)
  );

  assign w_last = (r_cnt == LAST_BIT);

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next_state = RUN;
      end
      RUN: begin
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_opa      <= '0;
      r_opb      <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_c_msb_in <= 1'b0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            r_opa   <= bus.a;
            r_opb   <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_carry <= w_co;
          // Carry produced by bit WIDTH-2 is the carry into the MSB.
          if (r_cnt == MSB_M1) r_c_msb_in <= w_co;
          if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= r_c_msb_in ^ w_co;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and randomised checks of bit_serial_adder at WIDTH=8 and WIDTH=16.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bsa_if #(.WIDTH(8))  if8  ();
  bsa_if #(.WIDTH(16)) if16 ();

  bit_serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  bit_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] e_sum;
    logic       e_cout;
    logic       e_ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                     input logic [7:0] es, input logic ec, input logic ev, input string tag);
    int lat;
    lat = 0;
    while (!if8.in_ready && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_in_ready"}, 32'(if8.in_ready), 32'd1);
    if8.a = a; if8.b = b; if8.sub = sub; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_sum"},  32'(if8.sum),  32'(es));
    chk({tag, "_cout"}, 32'(if8.cout), 32'(ec));
    chk({tag, "_ovf"},  32'(if8.ovf),  32'(ev));
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    chk({tag, "_back_idle"}, {30'd0, if8.in_ready, if8.out_valid}, 32'b10);
  endtask

  vec_t vecs[10];

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic saw;
    logic [15:0] ra, rb, rbb, rsum;
    logic        rsub, rcout, rovf;
    logic [16:0] full;

    vecs[0] = '{8'h3C, 8'h2A, 1'b0, 8'h66, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};
    vecs[9] = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0};

    if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.sub = 0; if8.out_ready = 0;
    if16.in_valid = 0; if16.a = 0; if16.b = 0; if16.sub = 0; if16.out_ready = 0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready",  32'(if8.in_ready),  32'd1);
    chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("rst_sum",       32'(if8.sum),       32'd0);
    chk("rst_cout_ovf",  {30'd0, if8.cout, if8.ovf}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 10; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].e_sum, vecs[i].e_cout,
          vecs[i].e_ovf, $sformatf("vec%0d", i));

    // Back-pressure in DONE with a competing request on the input side
    if8.a = 8'h3C; if8.b = 8'h2A; if8.sub = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("stall_latency", 32'(lat), 32'd8);
    if8.a = 8'h11; if8.b = 8'h22; if8.sub = 1'b1; if8.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_sum", k), 32'(if8.sum), 32'h66);
      chk($sformatf("stall%0d_hs", k), {29'd0, if8.out_valid, if8.in_ready, if8.cout ^ if8.ovf},
          32'b100);
    end
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    chk("stall_release_hs", {30'd0, if8.in_ready, if8.out_valid}, 32'b10);
    chk("stall_release_sum", 32'(if8.sum), 32'h66);
    @(posedge clk); #1;
    chk("stall_no_accept", 32'(if8.in_ready), 32'd1);

    // Reset while RUN at count 3
    if8.a = 8'h55; if8.b = 8'h11; if8.sub = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(if8.in_ready), 32'd1);
    chk("abort_sum", 32'(if8.sum), 32'd0);
    chk("abort_cout_ovf", {30'd0, if8.cout, if8.ovf}, 32'd0);
    saw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (if8.out_valid) saw = 1'b1;
    end
    chk("abort_no_out_valid", 32'(saw), 32'd0);
    op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "post_abort");

    // WIDTH=16 random ops with random result stalls
    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rsub = 1'($urandom);
      rbb  = rsub ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, rbb} + 17'(rsub);
      rsum = full[15:0];
      rcout = full[16];
      rovf = (ra[15] == rbb[15]) && (rsum[15] != ra[15]);
      lat = 0;
      while (!if16.in_ready && lat < 50) begin
        @(posedge clk); #1; lat++;
      end
      if16.a = ra; if16.b = rb; if16.sub = rsub; if16.in_valid = 1'b1;
      @(posedge clk); #1;
      if16.in_valid = 1'b0;
      lat = 0;
      while (!if16.out_valid && lat < 60) begin
        @(posedge clk); #1; lat++;
      end
      chk($sformatf("r16_%0d_latency", n), 32'(lat), 32'd16);
      chk($sformatf("r16_%0d_sum", n), 32'(if16.sum), 32'(rsum));
      chk($sformatf("r16_%0d_cout_ovf", n), {30'd0, if16.cout, if16.ovf}, {30'd0, rcout, rovf});
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk($sformatf("r16_%0d_hold", n), {if16.out_valid, 15'd0, if16.sum}, {1'b1, 15'd0, rsum});
      end
      if16.out_ready = 1'b1;
      @(posedge clk); #1;
      if16.out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
